fmap_capture_seq: RTL and testbench

Parametrised multi-layer feature-map capture engine that sequences through NUM_LAYERS CNN layers in order. For each layer it captures one selected channel's output columns and packs them into BRAM_W-bit words written to the local result BRAM. It generalises the fixed two-layer capture/arbitration top with runtime-configured column height, column count, base address and channel select per layer. It adds drop detection and abort.

---
 rtl/fmap_capture_seq_pkg.sv | 10 +
 rtl/fmap_capture_seq_if.sv | 39 +++
 rtl/fmap_capture_seq_col_packer.sv | 38 +++
 rtl/fmap_capture_seq.sv | 156 +++++++++++++++
 tb/tb_fmap_capture_seq.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fmap_capture_seq_pkg.sv
// fmap_capture_pkg: FSM state type, default pixels-per-word and the words-per-column helper
package fmap_capture_pkg;
    localparam int DATA_WIDTH_DEF = 16;
    localparam int BRAM_W_DEF = 256;
    localparam int PPW = BRAM_W_DEF / DATA_WIDTH_DEF;
    typedef enum logic [2:0] {S_IDLE, S_CAPTURE, S_WRITE, S_NEXT, S_DONE} state_t;
    function automatic int wpc(input int h, input int ppw = PPW);
        return (h + ppw - 1) / ppw;
    endfunction
endpackage

// File: rtl/fmap_capture_seq_if.sv
// fmap_capture_seq_if: control, column and BRAM write bus; csum exists only with FMAP_CAPTURE_CSUM_EN
interface fmap_capture_seq_if #(
    parameter int NUM_LAYERS = 2,
    parameter int NUM_CH = 8,
    parameter int MAX_COL = 24,
    parameter int DATA_WIDTH = 16,
    parameter int BRAM_W = 256,
    parameter int ADDR_W = 12
);
    localparam int LW = NUM_LAYERS > 1 ? $clog2(NUM_LAYERS) : 1;
    localparam int CW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
    logic start, abort;
    logic [CW-1:0] ch_sel;
    logic [NUM_LAYERS-1:0] col_valid;
    logic [NUM_LAYERS*NUM_CH*MAX_COL*DATA_WIDTH-1:0] col_data;
    logic [NUM_LAYERS*8-1:0] cfg_col_h, cfg_num_cols;
    logic [NUM_LAYERS*ADDR_W-1:0] cfg_base;
    logic [ADDR_W-1:0] bram_addr;
    logic [BRAM_W-1:0] bram_wrdata;
    logic bram_we, col_ready, busy, done, overflow;
    logic [LW-1:0] layer_idx;
`ifdef FMAP_CAPTURE_CSUM_EN
    logic [31:0] csum;
`endif
    modport master (
        output start, abort, ch_sel, col_valid, col_data, cfg_col_h, cfg_num_cols, cfg_base,
        input bram_addr, bram_wrdata, bram_we, col_ready, busy, done, layer_idx, overflow
`ifdef FMAP_CAPTURE_CSUM_EN
        , csum
`endif
    );
    modport slave (
        input start, abort, ch_sel, col_valid, col_data, cfg_col_h, cfg_num_cols, cfg_base,
        output bram_addr, bram_wrdata, bram_we, col_ready, busy, done, layer_idx, overflow
`ifdef FMAP_CAPTURE_CSUM_EN
        , csum
`endif
    );
endinterface

// File: rtl/fmap_capture_seq_col_packer.sv
// fmap_col_packer: column register and zero-filled word slicer; per-word pixel sum with FMAP_CAPTURE_CSUM_EN
module fmap_col_packer #(
    parameter int MAX_COL = 24,
    parameter int DATA_WIDTH = 16,
    parameter int BRAM_W = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic [MAX_COL*DATA_WIDTH-1:0] col_i,
    input  logic [7:0] h_i,
    input  logic [7:0] w_i,
    output logic [BRAM_W-1:0] word_o
`ifdef FMAP_CAPTURE_CSUM_EN
    , output logic [31:0] sum_o
`endif
);
    localparam int PPW_L = BRAM_W / DATA_WIDTH;
    logic [MAX_COL*DATA_WIDTH-1:0] col_q;
    // column register, loaded when a column is accepted
    always_ff @(posedge clk or posedge rst)
        if (rst) col_q <= '0;
        else if (load_i) col_q <= col_i;
    // slice word w_i; pixels at or above the column height read as zero
    always_comb begin
        word_o = '0;
`ifdef FMAP_CAPTURE_CSUM_EN
        sum_o = '0;
`endif
        for (int i = 0; i < PPW_L; i++)
            if (int'(w_i) * PPW_L + i < int'(h_i) && int'(w_i) * PPW_L + i < MAX_COL) begin
                word_o[i*DATA_WIDTH +: DATA_WIDTH] = col_q[(int'(w_i) * PPW_L + i)*DATA_WIDTH +: DATA_WIDTH];
`ifdef FMAP_CAPTURE_CSUM_EN
                sum_o = sum_o + 32'(col_q[(int'(w_i) * PPW_L + i)*DATA_WIDTH +: DATA_WIDTH]);
`endif
            end
    end
endmodule

// File: rtl/fmap_capture_seq.sv
// fmap_capture_seq: multi-layer feature-map capture FSM, counters and BRAM address generation.
// Define FMAP_CAPTURE_CSUM_EN to add the run pixel checksum output (bus.csum).
module fmap_capture_seq
    import fmap_capture_pkg::*;
#(
    parameter int NUM_LAYERS = 2,
    parameter int NUM_CH = 8,
    parameter int MAX_COL = 24,
    parameter int DATA_WIDTH = 16,
    parameter int BRAM_W = 256,
    parameter int ADDR_W = 12
) (
    input logic clk,
    input logic rst,
    fmap_capture_seq_if.slave bus
);
    localparam int LW = NUM_LAYERS > 1 ? $clog2(NUM_LAYERS) : 1;
    localparam int CW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
    localparam int PPW_L = BRAM_W / DATA_WIDTH;
    localparam int CBITS = MAX_COL * DATA_WIDTH;
    state_t state_q, state_d;
    logic [LW-1:0] layer_q, layer_d;
    logic [7:0] col_q, col_d, w_q, w_d, h_act;
    logic [CW-1:0] ch_q;
    logic [7:0] h_q [NUM_LAYERS];
    logic [7:0] ncols_q [NUM_LAYERS];
    logic [ADDR_W-1:0] base_q [NUM_LAYERS];
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [BRAM_W-1:0] data_q, data_d, word;
    logic [CBITS-1:0] col_sel;
    logic we_q, we_d, ovf_q, ovf_d, load, accept, skip, last_w, last_layer;
    int wpc_act;
`ifdef FMAP_CAPTURE_CSUM_EN
    logic [31:0] csum_q, wsum;
`endif
    assign h_act = h_q[layer_q];
    assign wpc_act = wpc(int'(h_act), PPW_L);
    assign skip = ncols_q[layer_q] == 8'd0 || h_act == 8'd0;
    assign last_w = int'(w_q) == wpc_act - 1;
    assign last_layer = layer_q == LW'(NUM_LAYERS - 1);
    assign accept = (state_q == S_IDLE || state_q == S_DONE) && bus.start && !bus.abort;
    assign col_sel = bus.col_data[(int'(layer_q) * NUM_CH + int'(ch_q)) * CBITS +: CBITS];
    assign bus.bram_addr = addr_q;
    assign bus.bram_wrdata = data_q;
    assign bus.bram_we = we_q;
    assign bus.col_ready = state_q == S_CAPTURE && !skip;
    assign bus.busy = state_q == S_CAPTURE || state_q == S_WRITE || state_q == S_NEXT;
    assign bus.done = state_q == S_DONE;
    assign bus.layer_idx = layer_q;
    assign bus.overflow = ovf_q;

    fmap_col_packer #(.MAX_COL(MAX_COL), .DATA_WIDTH(DATA_WIDTH), .BRAM_W(BRAM_W)) u_packer (
        .clk(clk), .rst(rst), .load_i(load), .col_i(col_sel), .h_i(h_act), .w_i(w_q), .word_o(word)
`ifdef FMAP_CAPTURE_CSUM_EN
        , .sum_o(wsum)
`endif
    );

    // run configuration, captured on an accepted start; heights clamp to MAX_COL
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            ch_q <= '0;
            for (int l = 0; l < NUM_LAYERS; l++) begin
                h_q[l] <= '0;
                ncols_q[l] <= '0;
                base_q[l] <= '0;
            end
        end else if (accept) begin
            ch_q <= bus.ch_sel;
            for (int l = 0; l < NUM_LAYERS; l++) begin
                h_q[l] <= bus.cfg_col_h[l*8 +: 8] > 8'(MAX_COL) ? 8'(MAX_COL) : bus.cfg_col_h[l*8 +: 8];
                ncols_q[l] <= bus.cfg_num_cols[l*8 +: 8];
                base_q[l] <= bus.cfg_base[l*ADDR_W +: ADDR_W];
            end
        end

    // next state, counters and next BRAM write; abort overrides everything
    always_comb begin
        state_d = state_q;
        layer_d = layer_q;
        col_d = col_q;
        w_d = w_q;
        ovf_d = ovf_q;
        load = 1'b0;
        we_d = 1'b0;
        addr_d = '0;
        data_d = '0;
        if (bus.abort)
            state_d = S_IDLE;
        else
            case (state_q)
                S_IDLE, S_DONE:
                    if (bus.start) begin
                        state_d = S_CAPTURE;
                        layer_d = '0;
                        col_d = '0;
                        w_d = '0;
                        ovf_d = 1'b0;
                    end
                S_CAPTURE:
                    if (skip)
                        state_d = S_NEXT;
                    else if (bus.col_valid[layer_q]) begin
                        load = 1'b1;
                        w_d = '0;
                        state_d = S_WRITE;
                    end
                S_WRITE: begin
                    we_d = 1'b1;
                    addr_d = ADDR_W'(int'(base_q[layer_q]) + int'(col_q) * wpc_act + int'(w_q));
                    data_d = word;
                    ovf_d = ovf_q | bus.col_valid[layer_q];
                    w_d = last_w ? 8'd0 : w_q + 8'd1;
                    col_d = last_w ? col_q + 8'd1 : col_q;
                    state_d = !last_w ? S_WRITE : (col_q + 8'd1 == ncols_q[layer_q]) ? S_NEXT : S_CAPTURE;
                end
                S_NEXT: begin
                    col_d = '0;
                    layer_d = last_layer ? layer_q : layer_q + 1'b1;
                    state_d = last_layer ? S_DONE : S_CAPTURE;
                end
                default: state_d = S_IDLE;
            endcase
    end

    // FSM state, counters and registered BRAM write port
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q <= S_IDLE;
            layer_q <= '0;
            col_q <= '0;
            w_q <= '0;
            ovf_q <= 1'b0;
            we_q <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            state_q <= state_d;
            layer_q <= layer_d;
            col_q <= col_d;
            w_q <= w_d;
            ovf_q <= ovf_d;
            we_q <= we_d;
            addr_q <= addr_d;
            data_q <= data_d;
        end

`ifdef FMAP_CAPTURE_CSUM_EN
    // wrapping sum of every pixel written during the run
    always_ff @(posedge clk or posedge rst)
        if (rst) csum_q <= '0;
        else if (accept) csum_q <= '0;
        else if (state_q == S_WRITE && !bus.abort) csum_q <= csum_q + wsum;
    assign bus.csum = csum_q;
`endif
endmodule

// File: tb/tb_fmap_capture_seq.sv
// tb_fmap_capture_seq: directed-vector bench for fmap_capture_seq
module tb_fmap_capture_seq;
    import fmap_capture_pkg::*;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    fmap_capture_seq_if bus ();
    fmap_capture_seq dut (.clk(clk), .rst(rst), .bus(bus));
    int n_vec = 0;
    int n_err = 0;
    int idle_bad = 0;
    logic [11:0] log_a [$];
    logic [255:0] log_d [$];
    int log_l [$];
    logic [255:0] mem [int];

    // write monitor: log every BRAM write, flag non-zero address/data while idle
    always @(negedge clk)
        if (bus.bram_we) begin
            log_a.push_back(bus.bram_addr);
            log_d.push_back(bus.bram_wrdata);
            log_l.push_back(int'(bus.layer_idx));
        end else if (bus.bram_addr !== '0 || bus.bram_wrdata !== '0)
            idle_bad++;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] pix(input int l, input int c, input int k, input int p);
        return {1'b1, l[0], c[2:0], k[4:0], p[4:0], 1'b0};
    endfunction

    function automatic logic [255:0] exp_word(input int l, input int k, input int w, input int h);
        logic [255:0] r = '0;
        for (int i = 0; i < 16; i++)
            if (w * 16 + i < h) r[i*16 +: 16] = pix(l, 2, k, w * 16 + i);
        return r;
    endfunction

    function automatic int n_wr(input int s, input int l);
        int n = 0;
        for (int i = s; i < log_a.size(); i++) if (log_l[i] == l) n++;
        return n;
    endfunction

    task automatic load_mem(input int s);
        mem.delete();
        for (int i = s; i < log_a.size(); i++) mem[int'(log_a[i])] = log_d[i];
    endtask

    task automatic set_cfg(input int h0, input int n0, input int b0, input int h1, input int n1, input int b1);
        bus.cfg_col_h = {8'(h1), 8'(h0)};
        bus.cfg_num_cols = {8'(n1), 8'(n0)};
        bus.cfg_base = {12'(b1), 12'(b0)};
    endtask

    task automatic set_cols(input int k);
        for (int l = 0; l < 2; l++)
            for (int c = 0; c < 8; c++)
                for (int p = 0; p < 24; p++)
                    bus.col_data[((l * 8 + c) * 24 + p) * 16 +: 16] = pix(l, c, k, p);
    endtask

    task automatic do_start();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic send_col(input int l, input int k);
        int t = 0;
        while (!(bus.col_ready && int'(bus.layer_idx) == l) && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("col_ready_wait", t < 200, 1);
        set_cols(k);
        bus.col_valid[l] = 1'b1;
        @(negedge clk);
        bus.col_valid = '0;
    endtask

    task automatic run_layer(input int l, input int k0, input int n);
        for (int k = k0; k < n; k++) begin
            send_col(l, k);
            repeat (3) @(negedge clk);
        end
    endtask

    task automatic wait_done();
        int t = 0;
        while (!bus.done && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk("done", bus.done, 1);
        #1;
    endtask

    initial begin
        int s, t, c;
        logic [255:0] tmp;
        logic [11:0] q [$];
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.ch_sel = 3'd2;
        bus.col_valid = '0;
        bus.col_data = '0;
        set_cfg(24, 24, 'h000, 10, 10, 'h040);
        #12;
        chk("rst_we", bus.bram_we, 0);
        chk("rst_addr", bus.bram_addr, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_ready", bus.col_ready, 0);
        chk("rst_ovf", bus.overflow, 0);
        @(negedge clk);
        rst = 1'b0;

        // 1: nominal run
        s = log_a.size();
        do_start();
        chk("t1_busy", bus.busy, 1);
        chk("t1_ready", bus.col_ready, 1);
        send_col(0, 0);
        chk("t1_we_t", bus.bram_we, 0);
        @(negedge clk);
        chk("t1_we_t1", bus.bram_we, 1);
        chk("t1_addr0", bus.bram_addr, 0);
        run_layer(0, 1, 24);
        run_layer(1, 0, 10);
        wait_done();
        chk("t1_busy_end", bus.busy, 0);
        chk("t1_ovf", bus.overflow, 0);
        chk("t1_l0_writes", n_wr(s, 0), 48);
        chk("t1_l1_writes", n_wr(s, 1), 10);
        load_mem(s);
        for (int k = 0; k < 24; k++)
            for (int w = 0; w < 2; w++)
                chk("t1_l0_word", mem[k * wpc(24) + w], exp_word(0, k, w, 24));
        for (int k = 0; k < 10; k++)
            chk("t1_l1_word", mem['h40 + k * wpc(10)], exp_word(1, k, 0, 10));
        tmp = mem[0];
        chk("t1_pix2", tmp[47:32], 16'h9004);
        tmp = mem[1];
        chk("t1_w1_hi_zero", tmp[255:128], 0);
        tmp = mem['h40];
        chk("t1_l1_fill_zero", tmp[255:160], 0);

        // 2: back-to-back columns on layer 0
        s = log_a.size();
        do_start();
        set_cols(0);
        bus.col_valid[0] = 1'b1;
        t = 0;
        while (bus.layer_idx != 1'b1 && t < 400) begin
            @(negedge clk);
            t++;
        end
        bus.col_valid = '0;
        #1;
        chk("t2_reach_l1", t < 400, 1);
        chk("t2_ovf", bus.overflow, 1);
        chk("t2_l0_writes", n_wr(s, 0), 48);
        load_mem(s);
        c = 0;
        for (int a = 0; a < 48; a++) if (mem.exists(a)) c++;
        chk("t2_l0_span", c, 48);
        run_layer(1, 0, 10);
        wait_done();
        chk("t2_l1_writes", n_wr(s, 1), 10);
        chk("t2_ovf_sticky", bus.overflow, 1);

        // 3: layer 0 skipped
        set_cfg(24, 0, 'h000, 10, 10, 'h040);
        s = log_a.size();
        do_start();
        chk("t3_ovf_clr", bus.overflow, 0);
        chk("t3_done_clr", bus.done, 0);
        @(negedge clk);
        chk("t3_layer_c1", bus.layer_idx, 0);
        @(negedge clk);
        chk("t3_layer_c2", bus.layer_idx, 1);
        chk("t3_ready_c2", bus.col_ready, 1);
        run_layer(1, 0, 10);
        wait_done();
        chk("t3_l0_writes", n_wr(s, 0), 0);
        chk("t3_l1_writes", n_wr(s, 1), 10);

        // 4: abort during the sixth column of layer 0
        set_cfg(24, 24, 'h000, 10, 10, 'h040);
        s = log_a.size();
        do_start();
        run_layer(0, 0, 5);
        send_col(0, 5);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        chk("t4_we", bus.bram_we, 0);
        chk("t4_busy", bus.busy, 0);
        chk("t4_done", bus.done, 0);
        chk("t4_ready", bus.col_ready, 0);
        #1;
        chk("t4_l0_writes", n_wr(s, 0), 10);
        @(negedge clk);
        chk("t4_we_hold", bus.bram_we, 0);
        do_start();
        send_col(0, 0);
        set_cols(7);
        bus.col_valid[0] = 1'b1;
        @(negedge clk);
        bus.col_valid = '0;
        chk("t4_rerun_we", bus.bram_we, 1);
        chk("t4_rerun_addr", bus.bram_addr, 0);
        chk("t4_rerun_data", bus.bram_wrdata, exp_word(0, 0, 0, 24));
        chk("t4_drop_ovf", bus.overflow, 1);

        // 5: asynchronous reset during WRITE
        #1 rst = 1'b1;
        #1;
        chk("t5_we", bus.bram_we, 0);
        chk("t5_addr", bus.bram_addr, 0);
        chk("t5_data", bus.bram_wrdata, 0);
        chk("t5_busy", bus.busy, 0);
        chk("t5_ready", bus.col_ready, 0);
        chk("t5_ovf", bus.overflow, 0);
        chk("t5_layer", bus.layer_idx, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("t5_idle_busy", bus.busy, 0);
        chk("t5_idle_we", bus.bram_we, 0);

        // 6: layer 1 base near the top of the address space wraps
        set_cfg(24, 24, 'h000, 24, 2, 'hFFE);
        s = log_a.size();
        do_start();
        run_layer(0, 0, 24);
        run_layer(1, 0, 2);
        wait_done();
        for (int i = s; i < log_a.size(); i++) if (log_l[i] == 1) q.push_back(log_a[i]);
        chk("t6_l1_writes", q.size(), 4);
        chk("t6_addr0", q[0], 12'hFFE);
        chk("t6_addr1", q[1], 12'hFFF);
        chk("t6_addr2", q[2], 12'h000);
        chk("t6_addr3", q[3], 12'h001);
        load_mem(s);
        chk("t6_data_fff", mem['hFFF], exp_word(1, 0, 1, 24));
        chk("t6_data_000", mem[0], exp_word(1, 1, 0, 24));
        chk("idle_port_zero", idle_bad, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
